counting_tx: RTL and testbench

- Transmitter end of the 2-bit symbol link whose receiver locks on the sequence 01,10,11 and drops lock on symbol 00.
- Accepts a DATA_W-bit word over a valid/ready handshake and emits a frame, one symbol per clock on num[1:0]:
  - preamble 01,10,11;
  - one symbol per data bit, MSB first: bit 0 -> 01, bit 1 -> 10;
  - GAP_CYCLES idle 00 symbols.
- The data encoding never produces 00, so a downstream detector stays locked for the whole payload and unlocks on the first gap symbol.

---
 rtl/counting_tx.sv | 160 ++++++++++++++++
 tb/tb_counting_tx.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/counting_tx.sv
// ============================================================================
// counting_tx : 2-bit symbol link transmitter (preamble, MSB-first data, gap).
// Optional parity symbol enabled by macro COUNTING_TX_PARITY_EN.
// Rev 1.0
// ============================================================================
`default_nettype none

module counting_tx #(
  parameter int DATA_W     = 8,
  parameter int GAP_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [1:0]        num,
  output logic              sym_valid,
  output logic              busy,
  output logic              done
);

  localparam int BW = $clog2(DATA_W) + 1;
  localparam int GW = $clog2(GAP_CYCLES) + 1;
  localparam logic [BW-1:0] C_BIT_LAST = BW'(DATA_W - 1);
  localparam logic [GW-1:0] C_GAP_LAST = GW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE1 = 3'd1,
    S_PRE2 = 3'd2,
    S_PRE3 = 3'd3,
    S_DATA = 3'd4,
    S_PAR  = 3'd5,
    S_GAP  = 3'd6
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [GW-1:0]     gap_cnt_q, gap_cnt_d;
  logic [1:0]        num_q, num_d;
  logic              sym_valid_q, sym_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              w_accept;
  logic              w_gap_last;
`ifdef COUNTING_TX_PARITY_EN
  logic              par_q, par_d;
`endif

  assign w_gap_last = (gap_cnt_q == C_GAP_LAST);
  assign in_ready   = (state_q == S_IDLE) || ((state_q == S_GAP) && w_gap_last);
  assign w_accept   = in_valid && in_ready;

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
`ifdef COUNTING_TX_PARITY_EN
    par_d     = par_q;
`endif

    case (state_q)
      S_IDLE: ;
      S_PRE1: state_d = S_PRE2;
      S_PRE2: state_d = S_PRE3;
      S_PRE3: begin
        state_d   = S_DATA;
        bit_cnt_d = '0;
      end
      S_DATA: begin
        shreg_d   = shreg_q << 1;
        bit_cnt_d = bit_cnt_q + BW'(1);
        if (bit_cnt_q == C_BIT_LAST) begin
`ifdef COUNTING_TX_PARITY_EN
          state_d   = S_PAR;
`else
          state_d   = S_GAP;
          gap_cnt_d = '0;
`endif
        end
      end
`ifdef COUNTING_TX_PARITY_EN
      S_PAR: begin
        state_d   = S_GAP;
        gap_cnt_d = '0;
      end
`endif
      S_GAP: begin
        gap_cnt_d = gap_cnt_q + GW'(1);
        if (w_gap_last) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Accept overrides the IDLE hold and the GAP exit, giving back-to-back frames.
    if (w_accept) begin
      state_d = S_PRE1;
      shreg_d = in_data;
`ifdef COUNTING_TX_PARITY_EN
      par_d   = ^in_data;
`endif
    end

    // Outputs are registered alongside the state, so decode from the next state.
    num_d = 2'b00;
    case (state_d)
      S_PRE1:  num_d = 2'b01;
      S_PRE2:  num_d = 2'b10;
      S_PRE3:  num_d = 2'b11;
      S_DATA:  num_d = shreg_d[DATA_W-1] ? 2'b10 : 2'b01;
`ifdef COUNTING_TX_PARITY_EN
      S_PAR:   num_d = par_q ? 2'b10 : 2'b01;
`endif
      default: num_d = 2'b00;
    endcase

    sym_valid_d = (state_d != S_IDLE) && (state_d != S_GAP);
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_GAP) && (gap_cnt_d == C_GAP_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      num_q       <= 2'b00;
      sym_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef COUNTING_TX_PARITY_EN
      par_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      num_q       <= num_d;
      sym_valid_q <= sym_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef COUNTING_TX_PARITY_EN
      par_q       <= par_d;
`endif
    end
  end

  assign num       = num_q;
  assign sym_valid = sym_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

`default_nettype wire

// File: tb/tb_counting_tx.sv
// ============================================================================
// tb_counting_tx : directed self-checking bench for counting_tx.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_counting_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       iv1, iv3;
  logic [7:0] id1, id3;
  logic       ir1, ir3;
  logic [1:0] num1, num3;
  logic       sv1, sv3, busy1, busy3, done1, done3;

  int n_total = 0;
  int n_bad   = 0;

  logic [1:0] q_a5[$];
  logic [1:0] q_ff[$];
  logic [1:0] q_00[$];
  logic [1:0] q_5a[$];
  logic [1:0] q_07[$];

  always #5 clk = ~clk;

  counting_tx #(.DATA_W(8), .GAP_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_data(id1), .in_ready(ir1),
    .num(num1), .sym_valid(sv1), .busy(busy1), .done(done1)
  );

  counting_tx #(.DATA_W(8), .GAP_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv3), .in_data(id3), .in_ready(ir3),
    .num(num3), .sym_valid(sv3), .busy(busy3), .done(done3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Walks one frame already accepted; inject_at pulses a foreign word on dut1.
  task automatic frame_check(input string tag, input bit sel, input logic [1:0] exp_q[$],
                             input int gap, input int inject_at);
    int         len;
    int         lock_cycles;
    bit         locked;
    logic [1:0] p1, p2;
    len         = exp_q.size();
    lock_cycles = 0;
    locked      = 1'b0;
    p1          = 2'b00;
    p2          = 2'b00;
    for (int i = 0; i < len; i++) begin
      logic [1:0] s;
      s = sel ? num3 : num1;
      if (i == inject_at) begin
        iv1 = 1'b1;
        id1 = 8'h3C;
      end
      if (i == inject_at + 1) iv1 = 1'b0;
      chk($sformatf("%s_num%0d", tag, i), 32'(s), 32'(exp_q[i]));
      chk($sformatf("%s_sv%0d", tag, i), 32'(sel ? sv3 : sv1), 32'(i < len - gap));
      chk($sformatf("%s_done%0d", tag, i), 32'(sel ? done3 : done1), 32'(i == len - 1));
      chk($sformatf("%s_rdy%0d", tag, i), 32'(sel ? ir3 : ir1), 32'(i == len - 1));
      chk($sformatf("%s_busy%0d", tag, i), 32'(sel ? busy3 : busy1), 32'd1);
      if (locked && s != 2'b00) lock_cycles++;
      if (s == 2'b00) locked = 1'b0;
      else if (p2 == 2'b01 && p1 == 2'b10 && s == 2'b11) locked = 1'b1;
      p2 = p1;
      p1 = s;
      tick();
    end
    chk($sformatf("%s_lock_span", tag), 32'(lock_cycles), 32'(len - gap - 3));
  endtask

  initial begin
    q_a5 = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd1, 2'd2, 2'd1, 2'd1, 2'd2, 2'd1, 2'd2, 2'd0};
    q_ff = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd0};
    q_00 = '{2'd1, 2'd2, 2'd3, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd0};
    q_5a = '{2'd1, 2'd2, 2'd3, 2'd1, 2'd2, 2'd1, 2'd2, 2'd2, 2'd1, 2'd2, 2'd1, 2'd0};
    q_07 = '{2'd1, 2'd2, 2'd3, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2,
             2'd0, 2'd0, 2'd0};
`ifdef COUNTING_TX_PARITY_EN
    q_a5.insert(11, 2'd1);
    q_ff.insert(11, 2'd1);
    q_00.insert(11, 2'd1);
    q_5a.insert(11, 2'd1);
    q_07.insert(11, 2'd2);
`endif

    rst_n = 1'b0;
    iv1 = 1'b0; id1 = 8'h00;
    iv3 = 1'b0; id3 = 8'h00;
    repeat (3) tick();
    chk("rst_num", 32'(num1), 32'd0);
    chk("rst_sv", 32'(sv1), 32'd0);
    chk("rst_busy", 32'(busy1), 32'd0);
    chk("rst_done", 32'(done1), 32'd0);
    chk("rst_rdy", 32'(ir1), 32'd1);
    chk("rst_rdy3", 32'(ir3), 32'd1);
    rst_n = 1'b1;
    tick();
    chk("post_rst_rdy", 32'(ir1), 32'd1);

    // Single frame 0xA5
    id1 = 8'hA5; iv1 = 1'b1;
    tick();
    iv1 = 1'b0;
    frame_check("a5", 1'b0, q_a5, 1, -10);
    chk("a5_idle_num", 32'(num1), 32'd0);
    chk("a5_idle_busy", 32'(busy1), 32'd0);
    chk("a5_idle_rdy", 32'(ir1), 32'd1);

    // Back-to-back 0xFF then 0x00 with in_valid held
    id1 = 8'hFF; iv1 = 1'b1;
    tick();
    id1 = 8'h00;
    frame_check("ff", 1'b0, q_ff, 1, -10);
    iv1 = 1'b0;
    frame_check("z0", 1'b0, q_00, 1, -10);
    chk("b2b_idle_busy", 32'(busy1), 32'd0);
    chk("b2b_idle_num", 32'(num1), 32'd0);

    // Word offered while busy is dropped
    id1 = 8'h5A; iv1 = 1'b1;
    tick();
    iv1 = 1'b0;
    frame_check("ign", 1'b0, q_5a, 1, 6);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("ign_idle_num%0d", k), 32'(num1), 32'd0);
      chk($sformatf("ign_idle_busy%0d", k), 32'(busy1), 32'd0);
      tick();
    end

    // Asynchronous reset during PRE3
    id1 = 8'hC3; iv1 = 1'b1;
    tick();
    iv1 = 1'b0;
    tick();
    tick();
    chk("mid_pre3_num", 32'(num1), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_num", 32'(num1), 32'd0);
    chk("mid_rst_sv", 32'(sv1), 32'd0);
    chk("mid_rst_busy", 32'(busy1), 32'd0);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("mid_after_num%0d", k), 32'(num1), 32'd0);
      chk($sformatf("mid_after_busy%0d", k), 32'(busy1), 32'd0);
      chk($sformatf("mid_after_rdy%0d", k), 32'(ir1), 32'd1);
      tick();
    end

    // Three-symbol gap, word 0x07
    id3 = 8'h07; iv3 = 1'b1;
    tick();
    iv3 = 1'b0;
    frame_check("g3", 1'b1, q_07, 3, -10);
    chk("g3_idle_busy", 32'(busy3), 32'd0);
    chk("g3_idle_rdy", 32'(ir3), 32'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
